prog_address_decoder: RTL and testbench

PROG_ADDRESS_DECODER -- requirements
Module: prog_address_decoder

---
 rtl/prog_address_decoder.sv | 191 +++++++++++++++++++
 tb/tb_prog_address_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_address_decoder.sv
// Programmable bus address decoder with a register-mapped window table.
// It also provides a device-acknowledge timeout and a sticky bus-fault record.
module prog_address_decoder #(
  parameter int NUM_WINDOWS = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE = 'h0050_F000
) (
  input  logic                   Clock,
  input  logic                   Reset_H,
  input  logic [ADDR_WIDTH-1:0]  Address,
  input  logic                   AS_L,
  input  logic                   WE_L,
  input  logic [15:0]            DataIn,
  output logic [15:0]            DataOut,
  input  logic [NUM_WINDOWS-1:0] DevAck_H,
  output logic [NUM_WINDOWS-1:0] Select_H,
  output logic                   Dtack_L,
  output logic                   Berr_L,
  output logic                   Fault_H
);

  // state    | meaning
  // IDLE     | waiting for a fresh strobe (one seen high since reset)
  // DECODE   | latched address decoded; config access performed here
  // WAIT_ACK | window selected, counting toward timeout
  // ACK      | Dtack_L asserted until strobe released
  // FAULT    | Berr_L asserted until strobe released
  typedef enum logic [2:0] {IDLE, DECODE, WAIT_ACK, ACK, FAULT} stateType;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  stateType state, stateNext;

  logic                   armed;
  logic [ADDR_WIDTH-1:0]  addrLatch;
  logic                   weLatch;
  logic [31:0]            base [NUM_WINDOWS];
  logic [31:0]            mask [NUM_WINDOWS];
  logic [NUM_WINDOWS-1:0] enable;
  logic [NUM_WINDOWS-1:0] hitVec;
  logic [NUM_WINDOWS-1:0] selReg;
  logic                   hitFound;
  logic [15:0]            cnt;
  logic [15:0]            cntInc;
  logic [15:0]            rdData;
  logic [15:0]            cfgRead;
  logic [31:0]            faultAddr;
  logic [31:0]            addr32;
  logic                   faultFlag;
  logic                   cfgHit;
  logic                   cfgWrite;
  logic [7:0]             wordIdx;
  logic [4:0]             winIdx;
  logic [1:0]             fieldIdx;

  assign addr32   = 32'(addrLatch);
  assign cfgHit   = (addrLatch[ADDR_WIDTH-1:9] == CFG_BASE[ADDR_WIDTH-1:9]);
  assign wordIdx  = addrLatch[8:1];
  assign winIdx   = wordIdx[6:2];
  assign fieldIdx = wordIdx[1:0];
  assign cntInc   = cnt + 16'd1;
  assign cfgWrite = (state == DECODE) && !AS_L && cfgHit && !weLatch;

  // Lowest enabled matching window wins, so hitVec is at most one-hot.
  always_comb begin
    hitVec   = '0;
    hitFound = 1'b0;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (!hitFound && enable[i] && (((addr32 ^ base[i]) & mask[i]) == 32'h0)) begin
        hitVec[i] = 1'b1;
        hitFound  = 1'b1;
      end
    end
  end

  always_comb begin
    cfgRead = '0;
    if (!wordIdx[7]) begin
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        if (winIdx == 5'(i)) begin
          case (fieldIdx)
            2'd0: cfgRead = base[i][31:16];
            2'd1: cfgRead = base[i][15:0];
            2'd2: cfgRead = mask[i][31:16];
            default: cfgRead = mask[i][15:0];
          endcase
        end
      end
    end else begin
      case (wordIdx[6:0])
        7'h00: cfgRead = 16'(enable);
        7'h01: cfgRead = {15'b0, faultFlag};
        7'h02: cfgRead = faultAddr[31:16];
        7'h03: cfgRead = faultAddr[15:0];
        default: cfgRead = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (armed && !AS_L) stateNext = DECODE;
      DECODE: begin
        if (AS_L)             stateNext = IDLE;
        else if (cfgHit)      stateNext = ACK;
        else if (|hitVec)     stateNext = WAIT_ACK;
        else                  stateNext = FAULT;
      end
      WAIT_ACK: begin
        if (AS_L)                          stateNext = IDLE;
        else if (|(DevAck_H & selReg))     stateNext = ACK;
        else if (cntInc == TIMEOUT_LIM)    stateNext = FAULT;
      end
      ACK, FAULT: if (AS_L) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // armed blocks a strobe that was already low across reset from starting a cycle.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      armed     <= 1'b0;
      addrLatch <= '0;
      weLatch   <= 1'b1;
      selReg    <= '0;
      cnt       <= '0;
      rdData    <= '0;
      faultFlag <= 1'b0;
      faultAddr <= '0;
    end else begin
      if (AS_L) armed <= 1'b1;
      if (state == IDLE && stateNext == DECODE) begin
        addrLatch <= Address;
        weLatch   <= WE_L;
      end
      if (state == DECODE && stateNext == WAIT_ACK)       selReg <= hitVec;
      else if (stateNext == IDLE || stateNext == FAULT)   selReg <= '0;
      if (state == DECODE)                                cnt <= '0;
      else if (state == WAIT_ACK && stateNext == WAIT_ACK) cnt <= cntInc;
      if (state == DECODE && stateNext == ACK)            rdData <= weLatch ? cfgRead : 16'h0;
      else if (stateNext == IDLE)                         rdData <= '0;
      if (stateNext == FAULT && state != FAULT) begin
        faultFlag <= 1'b1;
        faultAddr <= addr32;
      end else if (cfgWrite && wordIdx == 8'h81 && DataIn[0]) begin
        faultFlag <= 1'b0;
      end
    end
  end

  // Window 0 comes out of reset mapping the boot ROM at 0000_0000-0000_7FFF.
  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        base[i] <= '0;
        mask[i] <= (i == 0) ? 32'hFFFF_8000 : 32'h0;
      end
      enable    <= '0;
      enable[0] <= 1'b1;
    end else if (cfgWrite) begin
      if (!wordIdx[7]) begin
        for (int i = 0; i < NUM_WINDOWS; i++) begin
          if (winIdx == 5'(i)) begin
            case (fieldIdx)
              2'd0: base[i][31:16] <= DataIn;
              2'd1: base[i][15:0]  <= DataIn;
              2'd2: mask[i][31:16] <= DataIn;
              default: mask[i][15:0] <= DataIn;
            endcase
          end
        end
      end else if (wordIdx[6:0] == 7'h00) begin
        enable <= DataIn[NUM_WINDOWS-1:0];
      end
    end
  end

  assign Select_H = selReg;
  assign Dtack_L  = (state != ACK);
  assign Berr_L   = (state != FAULT);
  assign DataOut  = rdData;
  assign Fault_H  = faultFlag;

endmodule

// File: tb/tb_prog_address_decoder.sv
// Directed bench for prog_address_decoder; expected responses are queued by the
// stimulus and checked by a monitor when Dtack_L or Berr_L asserts.
module tb_prog_address_decoder;
  localparam int NW = 8;
  localparam int AW = 32;
  localparam int TO = 4;
  localparam logic [31:0] CFG = 32'h0050_F000;

  logic          Clock;
  logic          Reset_H;
  logic [AW-1:0] Address;
  logic          AS_L;
  logic          WE_L;
  logic [15:0]   DataIn;
  logic [15:0]   DataOut;
  logic [NW-1:0] DevAck_H;
  logic [NW-1:0] Select_H;
  logic          Dtack_L;
  logic          Berr_L;
  logic          Fault_H;

  prog_address_decoder #(
    .NUM_WINDOWS(NW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CFG_BASE(CFG)
  ) dut (
    .Clock(Clock), .Reset_H(Reset_H), .Address(Address), .AS_L(AS_L),
    .WE_L(WE_L), .DataIn(DataIn), .DataOut(DataOut), .DevAck_H(DevAck_H),
    .Select_H(Select_H), .Dtack_L(Dtack_L), .Berr_L(Berr_L), .Fault_H(Fault_H)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        isErr;
    logic [7:0]  sel;
    logic [15:0] data;
    int          id;
  } respT;

  respT expQ[$];
  respT monE;
  int checks = 0;
  int fails = 0;
  int txnId = 0;
  logic respPrev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on the first cycle a response is presented.
  always @(negedge Clock) begin
    if (!Reset_H && (!Dtack_L || !Berr_L) && !respPrev) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected response: Dtack_L=%b Berr_L=%b, none expected", Dtack_L, Berr_L);
      end else begin
        monE = expQ.pop_front();
        check($sformatf("txn%0d berr", monE.id), 32'(!Berr_L), 32'(monE.isErr));
        check($sformatf("txn%0d select", monE.id), 32'(Select_H), 32'(monE.sel));
        check($sformatf("txn%0d data", monE.id), 32'(DataOut), 32'(monE.data));
      end
    end
    respPrev = !Dtack_L || !Berr_L;
  end

  task automatic busAccess(input logic [31:0] addr, input logic weL, input logic [15:0] data,
                           input logic [7:0] ackVec, input int ackDelay, input logic isErr,
                           input logic [7:0] expSel, input logic [15:0] expData, input int expCycle);
    respT e;
    int cyc;
    int selSeen;
    int respCyc;
    bit done;
    e.isErr = isErr;
    e.sel   = isErr ? 8'h00 : expSel;
    e.data  = expData;
    e.id    = txnId;
    expQ.push_back(e);
    @(posedge Clock); #1;
    Address = addr; WE_L = weL; DataIn = data; AS_L = 1'b0;
    cyc = 0; selSeen = 0; done = 0; respCyc = -1;
    while (!done && cyc < 40) begin
      @(negedge Clock);
      if (Select_H != 0) begin
        if (selSeen == 0) begin
          check($sformatf("txn%0d first select", txnId), 32'(Select_H), 32'(expSel));
          check($sformatf("txn%0d select latency", txnId), cyc, 2);
        end
        selSeen++;
        if (selSeen == ackDelay) DevAck_H = ackVec;
      end
      if (!Dtack_L || !Berr_L) begin
        done = 1;
        respCyc = cyc;
      end
      cyc++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL txn%0d no response: waited %0d cycles, expected one at cycle %0d", txnId, cyc, expCycle);
    end else begin
      check($sformatf("txn%0d response cycle", txnId), respCyc, expCycle);
    end
    @(posedge Clock); #1;
    AS_L = 1'b1; DevAck_H = '0; WE_L = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check($sformatf("txn%0d release", txnId), {30'b0, Dtack_L, Berr_L}, 32'h3);
    txnId++;
  endtask

  task automatic cfgWr(input logic [8:0] off, input logic [15:0] data);
    busAccess(CFG + 32'(off), 1'b0, data, 8'h00, 0, 1'b0, 8'h00, 16'h0000, 2);
  endtask

  task automatic cfgRd(input logic [8:0] off, input logic [15:0] expData);
    busAccess(CFG + 32'(off), 1'b1, 16'h0000, 8'h00, 0, 1'b0, 8'h00, expData, 2);
  endtask

  task automatic abortAccess(input logic [31:0] addr, input logic viaReset, input logic [7:0] expSel);
    @(posedge Clock); #1;
    Address = addr; WE_L = 1'b1; AS_L = 1'b0;
    repeat (3) @(negedge Clock);
    check("abort select before", 32'(Select_H), 32'(expSel));
    if (viaReset) begin
      Reset_H = 1'b1;
      @(negedge Clock);
      Reset_H = 1'b0;
      repeat (4) @(negedge Clock);
      check("reset abort idle select", 32'(Select_H), 32'h0);
      check("reset abort idle strobes", {30'b0, Dtack_L, Berr_L}, 32'h3);
      AS_L = 1'b1;
    end else begin
      AS_L = 1'b1;
      @(negedge Clock);
      check("abort select after", 32'(Select_H), 32'h0);
      check("abort strobes", {30'b0, Dtack_L, Berr_L}, 32'h3);
    end
    repeat (3) @(negedge Clock);
    check("abort fault flag", 32'(Fault_H), 32'h0);
    check("abort strobes later", {30'b0, Dtack_L, Berr_L}, 32'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_H = 1'b1; AS_L = 1'b1; WE_L = 1'b1; Address = '0; DataIn = '0; DevAck_H = '0;
    repeat (3) @(negedge Clock);
    check("reset select", 32'(Select_H), 32'h0);
    check("reset dtack", 32'(Dtack_L), 32'h1);
    check("reset berr", 32'(Berr_L), 32'h1);
    check("reset dataout", 32'(DataOut), 32'h0);
    check("reset fault", 32'(Fault_H), 32'h0);
    Reset_H = 1'b0;
    repeat (2) @(negedge Clock);

    // ROM window 0 after reset, ack on third wait cycle
    busAccess(32'h0000_1234, 1'b1, 16'h0, 8'h01, 3, 1'b0, 8'h01, 16'h0, 5);

    cfgWr(9'h008, 16'h0800); cfgWr(9'h00A, 16'h0000);
    cfgWr(9'h00C, 16'hFC00); cfgWr(9'h00E, 16'h0000);
    cfgWr(9'h100, 16'h0003);
    busAccess(32'h0BFF_FFFE, 1'b1, 16'h0, 8'h02, 1, 1'b0, 8'h02, 16'h0, 3);
    cfgRd(9'h008, 16'h0800);
    cfgRd(9'h00C, 16'hFC00);
    cfgRd(9'h100, 16'h0003);

    // window 2 overlaps window 1; the lower index must win
    cfgWr(9'h010, 16'h0800); cfgWr(9'h012, 16'h0000);
    cfgWr(9'h014, 16'hFC00); cfgWr(9'h016, 16'h0000);
    cfgWr(9'h100, 16'h0007);
    busAccess(32'h0800_0000, 1'b1, 16'h0, 8'h06, 1, 1'b0, 8'h02, 16'h0, 3);

    // ack arriving on the timeout cycle takes priority
    busAccess(32'h0000_0040, 1'b1, 16'h0, 8'h01, 4, 1'b0, 8'h01, 16'h0, 2 + TO);

    // only an unselected window acks: timeout to bus error
    busAccess(32'h0812_3456, 1'b1, 16'h0, 8'h04, 1, 1'b1, 8'h02, 16'h0, 2 + TO);
    check("fault after timeout", 32'(Fault_H), 32'h1);
    cfgRd(9'h104, 16'h0812);
    cfgRd(9'h106, 16'h3456);
    cfgRd(9'h102, 16'h0001);

    // unmapped address faults straight from decode
    busAccess(32'h3000_0000, 1'b1, 16'h0, 8'h00, 1, 1'b1, 8'h00, 16'h0, 2);
    cfgRd(9'h104, 16'h3000);
    cfgRd(9'h106, 16'h0000);
    cfgRd(9'h1F0, 16'h0000);
    cfgWr(9'h102, 16'h0001);
    check("fault cleared", 32'(Fault_H), 32'h0);
    cfgRd(9'h102, 16'h0000);

    abortAccess(32'h0000_0100, 1'b0, 8'h01);
    abortAccess(32'h0800_0000, 1'b1, 8'h02);

    // configuration back at reset values
    cfgRd(9'h004, 16'hFFFF);
    cfgRd(9'h006, 16'h8000);
    cfgRd(9'h00C, 16'h0000);
    cfgRd(9'h100, 16'h0001);
    busAccess(32'h0800_0000, 1'b1, 16'h0, 8'h02, 1, 1'b1, 8'h00, 16'h0, 2);

    repeat (3) @(negedge Clock);
    check("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
